// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with an 8-entry byte FIFO.
//
// The CPU writes bytes into the FIFO through the DATA word. The transmitter
// pops them and sends each one as a frame on TxD: a start bit, eight data
// bits LSB first, then a stop bit. Each bit lasts DIV clock cycles. IRQ is a
// level interrupt that stays high while the transmitter has drained and
// interrupts are enabled.
//
// Ports:
//   clk    system clock; all state changes on its rising edge
//   reset  asynchronous, active-high reset
//   Addr   word select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV
//   WE     write strobe, already qualified with device select
//   WD     write data
//   RD     combinational read data for Addr (reads have no side effects)
//   TxD    registered serial output, idles high
//   IRQ    ie & empty & ~busy
//
// Bus handshake: there is no valid/ready pair. A write takes effect on the
// rising edge where WE is high, so every write is accepted in one cycle.
// A DATA write that finds the FIFO full is dropped and sets the sticky ovf
// flag instead.
module uart_tx_dev #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        TxD,
  output logic        IRQ
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ie_q, ie_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   cur_div_q, cur_div_d;   // divisor latched at the start of the current bit
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic          full, empty, busy;
  logic          data_wr, push, pop, bit_end;
  logic          wd_unused;

  assign wd_unused = ^WD[31:16];

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q != ST_IDLE);
  assign data_wr = WE && (Addr == 2'd0);
  // Acceptance depends only on occupancy before the edge: a pop on the
  // same edge does not make room for a write that finds the FIFO full.
  assign push    = data_wr && !full;
  assign bit_end = (baud_cnt_q == cur_div_q - 16'd1);

  // Transmit FSM next state
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 16'd1;
    cur_div_d  = cur_div_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          cur_div_d = div_q;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          cur_div_d  = div_q;
          bit_idx_d  = 3'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          cur_div_d  = div_q;
          shift_d    = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          cur_div_d  = div_q;
          // A queued byte starts its start bit right away, with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase

    // TxD is registered from the state being entered, so it changes on the
    // same edge as the state.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO and register file next state
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    ie_d     = ie_q;
    div_d    = div_q;

    if (push) begin
      mem_d[wr_ptr_q] = WD[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (data_wr && full) begin
      ovf_d = 1'b1;
    end else if (WE && (Addr == 2'd1) && WD[3]) begin
      ovf_d = 1'b0;
    end
    if (WE && (Addr == 2'd2)) begin
      ie_d = WD[0];
    end
    if (WE && (Addr == 2'd3)) begin
      // A divisor below 2 would leave no room for the counter to count.
      div_d = (WD[15:0] < 16'd2) ? 16'd2 : WD[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ie_q       <= 1'b0;
      div_q      <= 16'(BAUD_DIV);
      cur_div_q  <= 16'(BAUD_DIV);
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      ie_q       <= ie_d;
      div_q      <= div_d;
      cur_div_q  <= cur_div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    case (Addr)
      2'd1:    RD = {23'd0, 5'(count_q), ovf_q, empty, full, busy};
      2'd2:    RD = {31'd0, ie_q};
      2'd3:    RD = {16'd0, div_q};
      default: RD = 32'd0;
    endcase
  end

  assign TxD = txd_q;
  assign IRQ = ie_q & empty & ~busy;

endmodule
